// File: rtl/fib_rf_sequencer.sv
//============================================================================
// Module      : fib_rf_sequencer
// Description : Drives a 2-read/1-write register bank to compute F(0)..F(n).
//               Every term is written into a ring of bank registers. F(n)
//               and a sticky overflow flag are returned on a start/busy/done
//               handshake.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module fib_rf_sequencer #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int BASE_REG = 1,
    parameter int RING_LEN = 4,
    parameter int N_W      = 6
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic [N_W-1:0]    n_in,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              overflow,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_dir,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [ADDR_W-1:0] rf_read_dir1,
    output logic [ADDR_W-1:0] rf_read_dir2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2
);

    // Ring bounds and the first three ring slots, ptr(0)..ptr(2).
    // RING_LEN >= 3 keeps BASE_REG+2 inside the ring.
    localparam logic [ADDR_W-1:0] C_RING_FIRST = ADDR_W'(BASE_REG);
    localparam logic [ADDR_W-1:0] C_RING_LAST  = ADDR_W'(BASE_REG + RING_LEN - 1);
    localparam logic [ADDR_W-1:0] C_PTR1       = ADDR_W'(BASE_REG + 1);
    localparam logic [ADDR_W-1:0] C_PTR2       = ADDR_W'(BASE_REG + 2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT0 = 3'd1,
        ST_INIT1 = 3'd2,
        ST_CALC  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_q,    state_d;
    logic [N_W-1:0]      n_q,        n_d;
    logic [N_W-1:0]      k_q,        k_d;
    // Three rotating ring pointers: ptr(k-2), ptr(k-1) and ptr(k).
    logic [ADDR_W-1:0]   p_km2_q,    p_km2_d;
    logic [ADDR_W-1:0]   p_km1_q,    p_km1_d;
    logic [ADDR_W-1:0]   p_k_q,      p_k_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;
    logic [DATA_W-1:0]   result_q,   result_d;
    logic                overflow_q, overflow_d;

    logic [DATA_W:0]     sum;
    logic [ADDR_W-1:0]   p_k_next;
    logic [ADDR_W-1:0]   done_ptr;

    // Carry-extended sum of the two previous terms.
    always_comb begin
        sum = {1'b0, rf_read_data1} + {1'b0, rf_read_data2};
    end

    // Next ring slot after ptr(k), wrapping back to the first ring register.
    always_comb begin
        p_k_next = (p_k_q == C_RING_LAST) ? C_RING_FIRST : p_k_q + 1'b1;
    end

    // Location of F(n): n=0 and n=1 finish before the pointers ever rotate.
    always_comb begin
        if (n_q == '0) begin
            done_ptr = p_km2_q;
        end else if (n_q == N_W'(1)) begin
            done_ptr = p_km1_q;
        end else begin
            done_ptr = p_k_q;
        end
    end

    // Sequencer next-state, bank access and handshake logic.
    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        k_d           = k_q;
        p_km2_d       = p_km2_q;
        p_km1_d       = p_km1_q;
        p_k_d         = p_k_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        result_d      = result_q;
        overflow_d    = overflow_q;
        rf_write_en   = 1'b0;
        rf_write_dir  = '0;
        rf_write_data = '0;
        rf_read_dir1  = '0;
        rf_read_dir2  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d        = n_in;
                    k_d        = '0;
                    overflow_d = 1'b0;
                    result_d   = '0;
                    busy_d     = 1'b1;
                    p_km2_d    = C_RING_FIRST;
                    p_km1_d    = C_PTR1;
                    p_k_d      = C_PTR2;
                    state_d    = ST_INIT0;
                end
            end
            ST_INIT0: begin
                rf_write_en   = 1'b1;
                rf_write_dir  = p_km2_q;
                rf_write_data = '0;
                state_d       = (n_q == '0) ? ST_DONE : ST_INIT1;
            end
            ST_INIT1: begin
                rf_write_en   = 1'b1;
                rf_write_dir  = p_km1_q;
                rf_write_data = DATA_W'(1);
                k_d           = N_W'(2);
                state_d       = (n_q == N_W'(1)) ? ST_DONE : ST_CALC;
            end
            ST_CALC: begin
                rf_read_dir1  = p_km2_q;
                rf_read_dir2  = p_km1_q;
                rf_write_en   = 1'b1;
                rf_write_dir  = p_k_q;
                rf_write_data = sum[DATA_W-1:0];
                if (sum[DATA_W]) begin
                    overflow_d = 1'b1;
                end
                if (k_q == n_q) begin
                    state_d = ST_DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    p_km2_d = p_km1_q;
                    p_km1_d = p_k_q;
                    p_k_d   = p_k_next;
                end
            end
            ST_DONE: begin
                rf_read_dir1 = done_ptr;
                result_d     = rf_read_data1;
                done_d       = 1'b1;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any run without a done pulse.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            k_q        <= '0;
            p_km2_q    <= C_RING_FIRST;
            p_km1_q    <= C_PTR1;
            p_k_q      <= C_PTR2;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            k_q        <= k_d;
            p_km2_q    <= p_km2_d;
            p_km1_q    <= p_km1_d;
            p_k_q      <= p_k_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_fib_rf_sequencer.sv
//============================================================================
// Module      : tb_fib_rf_sequencer
// Description : Directed bench for fib_rf_sequencer with a behavioural
//               2-read/1-write register bank.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_fib_rf_sequencer;

    logic        clk;
    logic        arst_n;
    logic        start;
    logic [5:0]  n_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        rf_write_en;
    logic [4:0]  rf_write_dir;
    logic [31:0] rf_write_data;
    logic [4:0]  rf_read_dir1;
    logic [4:0]  rf_read_dir2;
    logic [31:0] rf_read_data1;
    logic [31:0] rf_read_data2;

    int vectors;
    int miscompares;

    fib_rf_sequencer dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .start         (start),
        .n_in          (n_in),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .overflow      (overflow),
        .rf_write_en   (rf_write_en),
        .rf_write_dir  (rf_write_dir),
        .rf_write_data (rf_write_data),
        .rf_read_dir1  (rf_read_dir1),
        .rf_read_dir2  (rf_read_dir2),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register bank: register 0 reads as zero.
    logic [31:0] bank [32];
    logic [4:0]  wr_addr_log [$];
    logic [31:0] wr_data_log [$];
    int          bad_writes;
    int          done_pulses;

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = '0;
        bad_writes  = 0;
        done_pulses = 0;
    end

    always @(posedge clk) begin
        if (rf_write_en) begin
            if (rf_write_dir != 5'd0) bank[rf_write_dir] <= rf_write_data;
            wr_addr_log.push_back(rf_write_dir);
            wr_data_log.push_back(rf_write_data);
            if (rf_write_dir < 5'd1 || rf_write_dir > 5'd4) bad_writes++;
        end
        if (done) done_pulses++;
    end

    assign rf_read_data1 = (rf_read_dir1 == 5'd0) ? 32'd0 : bank[rf_read_dir1];
    assign rf_read_data2 = (rf_read_dir2 == 5'd0) ? 32'd0 : bank[rf_read_dir2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1 with the FSM idle; returns edges from accept to done.
    task automatic run(input logic [5:0] n, output int lat);
        start = 1'b1;
        n_in  = n;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
    endtask

    typedef struct {
        logic [5:0]  n;
        logic [31:0] exp_result;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat;
        int base;
        logic [4:0]  exp_addrs [11];
        vectors     = 0;
        miscompares = 0;
        start       = 1'b0;
        n_in        = '0;
        arst_n      = 1'b0;

        vecs[0] = '{6'd0,  32'd0,          1'b0};
        vecs[1] = '{6'd1,  32'd1,          1'b0};
        vecs[2] = '{6'd2,  32'd1,          1'b0};
        vecs[3] = '{6'd10, 32'd55,         1'b0};
        vecs[4] = '{6'd47, 32'hB11924E1,   1'b0};
        vecs[5] = '{6'd48, 32'h1E8D0A40,   1'b1};
        vecs[6] = '{6'd5,  32'd5,          1'b0};
        exp_addrs = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd1, 5'd2, 5'd3, 5'd4, 5'd1, 5'd2, 5'd3};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_result", {32'd0, result}, 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);
        chk("rst_we", {63'd0, rf_write_en}, 64'd0);
        arst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven runs.
        for (int v = 0; v < 7; v++) begin
            base = wr_addr_log.size();
            run(vecs[v].n, lat);
            chk($sformatf("latency_n%0d", vecs[v].n), 64'(lat), 64'(vecs[v].n) + 64'd2);
            chk($sformatf("result_n%0d", vecs[v].n), {32'd0, result}, {32'd0, vecs[v].exp_result});
            chk($sformatf("ovf_n%0d", vecs[v].n), {63'd0, overflow}, {63'd0, vecs[v].exp_ovf});
            chk($sformatf("busy_in_done_n%0d", vecs[v].n), {63'd0, busy}, 64'd0);
            if (vecs[v].n == 6'd0) begin
                chk("n0_write_count", 64'(wr_addr_log.size() - base), 64'd1);
                chk("n0_write_addr", {59'd0, wr_addr_log[base]}, 64'd1);
                chk("n0_write_data", {32'd0, wr_data_log[base]}, 64'd0);
            end
            if (vecs[v].n == 6'd1) begin
                chk("n1_write_count", 64'(wr_addr_log.size() - base), 64'd2);
                chk("n1_wr0", {27'd0, wr_addr_log[base], wr_data_log[base]}, {27'd0, 5'd1, 32'd0});
                chk("n1_wr1", {27'd0, wr_addr_log[base+1], wr_data_log[base+1]}, {27'd0, 5'd2, 32'd1});
            end
            if (vecs[v].n == 6'd10) begin
                chk("n10_write_count", 64'(wr_addr_log.size() - base), 64'd11);
                for (int i = 0; i < 11; i++)
                    chk($sformatf("n10_wr_addr%0d", i), {59'd0, wr_addr_log[base+i]}, {59'd0, exp_addrs[i]});
                chk("n10_reg3", {32'd0, bank[3]}, 64'd55);
                chk("n10_reg2", {32'd0, bank[2]}, 64'd34);
                chk("n10_reg1", {32'd0, bank[1]}, 64'd21);
                chk("n10_reg4", {32'd0, bank[4]}, 64'd13);
            end
            @(posedge clk); #1;
            chk($sformatf("done_one_cycle_n%0d", vecs[v].n), {63'd0, done}, 64'd0);
        end

        // Start during a run is ignored; start held in the done cycle relaunches.
        start = 1'b1;
        n_in  = 6'd20;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5) begin
                start = 1'b1;
                n_in  = 6'd3;
            end
            if (done) break;
        end
        chk("midrun_latency", 64'(lat), 64'd22);
        chk("midrun_result", {32'd0, result}, 64'd6765);
        @(posedge clk); #1;
        start = 1'b0;
        chk("relaunch_busy", {63'd0, busy}, 64'd1);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        chk("relaunch_latency", 64'(lat), 64'd5);
        chk("relaunch_result", {32'd0, result}, 64'd2);

        // Asynchronous reset in the middle of an n=30 run.
        @(posedge clk); #1;
        start = 1'b1;
        n_in  = 6'd30;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_result", {32'd0, result}, 64'd0);
        chk("arst_ovf", {63'd0, overflow}, 64'd0);
        chk("arst_bank_if", {26'd0, rf_write_en, rf_write_dir, rf_read_dir1, rf_read_dir2},
            64'd0);
        chk("arst_wdata", {32'd0, rf_write_data}, 64'd0);
        @(posedge clk); #1;
        arst_n = 1'b1;
        base = done_pulses;
        repeat (40) @(posedge clk);
        #1;
        chk("arst_no_done", 64'(done_pulses - base), 64'd0);
        chk("arst_idle_busy", {63'd0, busy}, 64'd0);
        run(6'd2, lat);
        chk("post_rst_latency", 64'(lat), 64'd4);
        chk("post_rst_result", {32'd0, result}, 64'd1);

        chk("ring_bounds", 64'(bad_writes), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
